// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
// Optional word parity is enabled with the IMEM_PARITY_EN macro.
package imem_pkg;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    // Callers zero-extend their word to this width.
    localparam int unsigned PAR_MAXW = 64;

    function automatic logic even_parity(
        input logic [PAR_MAXW-1:0] w
    );
        return ^w;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single write port, single read port word store.
// Read is combinational or registered depending on READ_LATENCY.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned W            = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 0,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    input  logic          i_blank,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb
            logic w_unused;
            assign w_unused = rst;
            assign o_rdata  = i_blank ? '0 : r_mem[i_raddr];
        end else begin : g_reg
            logic [W-1:0] r_rdata;
            // Old data on same-address collision: NBA ordering.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= i_blank ? '0 : r_mem[i_raddr];
                end
            end
            assign o_rdata = i_blank ? '0 : r_rdata;
        end
    endgenerate

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with self-clear, single writes and burst load.
// Define IMEM_PARITY_EN to store per-word parity and add parity_err.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 0,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_write,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] instruction_in,
    input  logic            load_start,
    input  logic [AW-1:0]   load_addr,
    input  logic [AW:0]     load_len,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    output logic            load_ready,
    output logic            load_done,
    output logic            init_busy,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] instruction
`ifdef IMEM_PARITY_EN
    ,
    output logic            parity_err
`endif
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned W = XLEN + 1;
`else
    localparam int unsigned W = XLEN;
`endif

    logic [1:0]      r_state;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   r_ptr;
    logic [AW:0]     r_remain;
    logic            r_done;

    logic            w_in_clear;
    logic            w_in_idle;
    logic            w_in_load;
    logic            w_hs;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [W-1:0]    w_wword;
    logic [W-1:0]    w_rword;

    assign w_in_clear = (r_state == ST_CLEAR);
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_load  = (r_state == ST_LOAD);
    assign w_hs       = w_in_load && load_valid;

    assign load_ready = w_in_load;
    assign load_done  = r_done;
    assign init_busy  = w_in_clear;

    // Write-port mux; load_start in IDLE drops a same-cycle write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
        unique case (1'b1)
            w_in_clear: begin
                w_we = 1'b1;
            end
            w_in_idle: begin
                w_we    = ins_write && !load_start;
                w_waddr = wr_addr;
                w_wdata = instruction_in;
            end
            w_in_load: begin
                w_we    = w_hs;
                w_waddr = r_ptr;
                w_wdata = load_data;
            end
            default: ;
        endcase
    end

`ifdef IMEM_PARITY_EN
    assign w_wword = {even_parity(PAR_MAXW'(w_wdata)), w_wdata};
    assign parity_err = ^w_rword;
`else
    assign w_wword = w_wdata;
`endif

    assign instruction = w_rword[XLEN-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ptr     <= '0;
            r_remain  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (1'b1)
                w_in_clear: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                w_in_idle: begin
                    if (load_start) begin
                        r_ptr    <= load_addr;
                        r_remain <= load_len;
                        if (load_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                w_in_load: begin
                    if (w_hs) begin
                        r_ptr    <= r_ptr + AW'(1);
                        r_remain <= r_remain - (AW+1)'(1);
                        if (r_remain == (AW+1)'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    imem_array #(
        .W            (W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wword),
        .i_raddr (rd_addr),
        .i_blank (w_in_clear),
        .o_rdata (w_rword)
    );

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable, DEPTH=16, combinational read.
// Parity checks compile in only with IMEM_PARITY_EN.
module tb_imem_loadable;

    localparam int unsigned D  = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ins_write;
    logic [AW-1:0] wr_addr;
    logic [31:0]   instruction_in;
    logic          load_start;
    logic [AW-1:0] load_addr;
    logic [AW:0]   load_len;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_ready;
    logic          load_done;
    logic          init_busy;
    logic [AW-1:0] rd_addr;
    logic [31:0]   instruction;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    imem_loadable #(
        .XLEN         (32),
        .DEPTH        (D),
        .READ_LATENCY (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ins_write      (ins_write),
        .wr_addr        (wr_addr),
        .instruction_in (instruction_in),
        .load_start     (load_start),
        .load_addr      (load_addr),
        .load_len       (load_len),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .init_busy      (init_busy),
        .rd_addr        (rd_addr),
        .instruction    (instruction)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(
        input logic [AW-1:0] a,
        input string         tag,
        input logic [31:0]   exp
    );
        rd_addr = a;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic wait_clear(
        output int   cyc,
        output logic saw_done
    );
        cyc      = 0;
        saw_done = 1'b0;
        while (init_busy && cyc < 64) begin
            if (load_done) saw_done = 1'b1;
            if (cyc == 3) begin
                rd_addr = 4'd5;
                #1;
                check("clr_forced0", instruction, 32'h0);
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        logic        saw;
        logic [31:0] acc;

        rst            = 1'b0;
        ins_write      = 1'b0;
        wr_addr        = '0;
        instruction_in = '0;
        load_start     = 1'b0;
        load_addr      = '0;
        load_len       = '0;
        load_valid     = 1'b0;
        load_data      = '0;
        rd_addr        = 4'd5;

        repeat (3) tick();
        check("rst_busy", 32'(init_busy), 32'h1);
        check("rst_ready", 32'(load_ready), 32'h0);
        check("rst_done", 32'(load_done), 32'h0);
        check("rst_instr", instruction, 32'h0);
`ifdef IMEM_PARITY_EN
        check("rst_parity", 32'(parity_err), 32'h0);
`endif

        rst = 1'b1;
        wait_clear(cyc, saw);
        check("busy_cycles", 32'(cyc), 32'd16);
        for (int i = 0; i < D; i++) begin
            rd(AW'(i), "clr_rd", 32'h0);
        end

        ins_write      = 1'b1;
        wr_addr        = 4'd3;
        instruction_in = 32'hDEADBEEF;
        tick();
        ins_write = 1'b0;
        rd(4'd3, "wr_hit", 32'hDEADBEEF);
        rd(4'd4, "wr_other", 32'h0);

        // Burst with a colliding single write that must lose.
        load_start     = 1'b1;
        load_addr      = 4'd14;
        load_len       = 5'd4;
        ins_write      = 1'b1;
        wr_addr        = 4'd5;
        instruction_in = 32'h55;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid     = 1'b0;
            wr_addr        = 4'd2;
            instruction_in = 32'h77;
            check("burst_ready", 32'(load_ready), 32'h1);
            tick();
            load_valid = 1'b1;
            load_data  = 32'(i + 1);
            check("burst_nodone", 32'(load_done), 32'h0);
            tick();
        end
        load_valid = 1'b0;
        ins_write  = 1'b0;
        check("burst_done", 32'(load_done), 32'h1);
        check("burst_rdy_off", 32'(load_ready), 32'h0);
        tick();
        check("burst_done_1cy", 32'(load_done), 32'h0);
        rd(4'd14, "burst_14", 32'd1);
        rd(4'd15, "burst_15", 32'd2);
        rd(4'd0, "burst_0", 32'd3);
        rd(4'd1, "burst_1", 32'd4);
        rd(4'd2, "burst_wr_ign", 32'h0);
        rd(4'd5, "start_wr_drop", 32'h0);
        rd(4'd3, "keep_3", 32'hDEADBEEF);

        load_start = 1'b1;
        load_addr  = 4'd6;
        load_len   = 5'd0;
        tick();
        load_start = 1'b0;
        check("len0_ready", 32'(load_ready), 32'h0);
        check("len0_done", 32'(load_done), 32'h1);
        tick();
        check("len0_ready2", 32'(load_ready), 32'h0);
        check("len0_done2", 32'(load_done), 32'h0);

        load_start = 1'b1;
        load_addr  = 4'd8;
        load_len   = 5'd4;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hA;
        tick();
        load_data  = 32'hB;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(init_busy), 32'h1);
        check("midrst_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
        tick();
        rst = 1'b1;
        wait_clear(cyc, saw);
        check("midrst_cycles", 32'(cyc), 32'd16);
        check("midrst_nodone", 32'(saw), 32'h0);
        acc = '0;
        for (int i = 0; i < D; i++) begin
            rd_addr = AW'(i);
            #1;
            acc = acc | instruction;
        end
        check("midrst_all0", acc, 32'h0);

`ifdef IMEM_PARITY_EN
        ins_write      = 1'b1;
        wr_addr        = 4'd7;
        instruction_in = 32'h1;
        tick();
        wr_addr        = 4'd8;
        instruction_in = 32'h3;
        tick();
        ins_write = 1'b0;
        rd_addr   = 4'd7;
        #1;
        check("par_clean7", 32'(parity_err), 32'h0);
        dut.u_array.r_mem[7] = dut.u_array.r_mem[7] ^ 33'h8;
        #1;
        check("par_flip7", 32'(parity_err), 32'h1);
        rd_addr = 4'd8;
        #1;
        check("par_clean8", 32'(parity_err), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
